// File: rtl/typing_pkg.sv
// Shared types and constants for the typing game controller.
// Optional build macro used by the top: TYPING_PENALTY_EN.
package typing_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    // Fibonacci taps 16,14,13,11 expressed on a left-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam bcd_t        BCD_MAX   = 4'd9;

    function automatic bcd_t draw_digit(input logic [15:0] lfsr);
        bcd_t cand;
        cand = lfsr[3:0];
        return (cand > BCD_MAX) ? cand - 4'd6 : cand;
    endfunction

    function automatic logic [7:0] to_bcd2(input int unsigned v);
        int unsigned tens;
        int unsigned ones;
        tens = (v / 10) % 10;
        ones = v % 10;
        return {tens[3:0], ones[3:0]};
    endfunction

endpackage

// File: rtl/typing_game_ctrl_bcd2_counter.sv
// Two-digit BCD counter: load beats inc beats dec; inc saturates at 99, dec floors at 00.
module bcd2_counter
    import typing_pkg::*;
#(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] value
);

    bcd_t       tens;
    bcd_t       ones;
    logic [7:0] value_nxt;

    assign tens = value[7:4];
    assign ones = value[3:0];

    always_comb begin
        value_nxt = value;
        if (load) begin
            value_nxt = load_val;
        end else if (inc) begin
            if (value == {BCD_MAX, BCD_MAX})
                value_nxt = value;
            else if (ones == BCD_MAX)
                value_nxt = {tens + 4'd1, 4'd0};
            else
                value_nxt = {tens, ones + 4'd1};
        end else if (dec) begin
            if (value == 8'h00)
                value_nxt = value;
            else if (ones == 4'd0)
                value_nxt = {tens - 4'd1, BCD_MAX};
            else
                value_nxt = {tens, ones - 4'd1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            value <= RST_VAL;
        else
            value <= value_nxt;
    end

endmodule

// File: rtl/typing_game_ctrl.sv
// Round control for the typing game: FSM, 1 s prescaler, LFSR target draw, score and timer.
// Build macro TYPING_PENALTY_EN makes a wrong key cost one point and redraw the target.
module typing_game_ctrl
    import typing_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned ROUND_SECS = 60,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] random_num,
    output logic [7:0] score,
    output logic [3:0] time_tens,
    output logic [3:0] time_ones,
    output logic       running,
    output logic       game_over
);

    localparam int unsigned          PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0]   PRESC_TC  = PRESC_W'(TICK_DIV - 1);
    localparam logic [7:0]           ROUND_BCD = to_bcd2(ROUND_SECS);

    state_t             state;
    state_t             state_nxt;
    logic               enter_run;
    logic               start_q;
    logic               start_rise;
    logic [15:0]        lfsr;
    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic [7:0]         timer_val;
    logic               key_match;
    logic               hit_p0;
    logic               score_dec;
    logic               redraw;

    assign start_rise = start & ~start_q;
    assign tick       = (state == RUN) && (presc == PRESC_TC);
    assign key_match  = (key_code == random_num);

    always_comb begin
        state_nxt = state;
        enter_run = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_rise) begin
                    state_nxt = RUN;
                    enter_run = 1'b1;
                end
            end
            RUN: begin
                if (timer_val == 8'h00)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            running   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_nxt;
            start_q   <= start;
            running   <= (state_nxt == RUN);
            game_over <= (state_nxt == DONE);
        end
    end

    // LFSR free-runs in every state so the first draw depends on when start arrives
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            presc <= '0;
        else if (enter_run || tick)
            presc <= '0;
        else if (state == RUN)
            presc <= presc + 1'b1;
    end

    // Stage p0: key compared against the displayed target, applied one edge later
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hit_p0 <= 1'b0;
        else
            hit_p0 <= (state == RUN) && key_valid && key_match;
    end

`ifdef TYPING_PENALTY_EN
    logic miss_p0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            miss_p0 <= 1'b0;
        else
            miss_p0 <= (state == RUN) && key_valid && !key_match;
    end

    assign score_dec = miss_p0;
    assign redraw    = hit_p0 | miss_p0;
`else
    assign score_dec = 1'b0;
    assign redraw    = hit_p0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            random_num <= 4'd0;
        else if (enter_run || redraw)
            random_num <= draw_digit(lfsr);
    end

    bcd2_counter #(
        .RST_VAL (8'h00)
    ) u_score (
        .clk      (clk),
        .reset    (reset),
        .load     (enter_run),
        .load_val (8'h00),
        .inc      (hit_p0),
        .dec      (score_dec),
        .value    (score)
    );

    bcd2_counter #(
        .RST_VAL (ROUND_BCD)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (enter_run),
        .load_val (ROUND_BCD),
        .inc      (1'b0),
        .dec      (tick),
        .value    (timer_val)
    );

    assign time_tens = timer_val[7:4];
    assign time_ones = timer_val[3:0];

endmodule

// File: tb/tb_typing_game_ctrl.sv
// Bench for typing_game_ctrl: short-round instance (a) for timing/reset, long-round instance (b) for score table.
module tb_typing_game_ctrl;

    localparam int unsigned TA   = 4;
    localparam int unsigned RA   = 3;
    localparam int unsigned TB   = 1000;
    localparam int unsigned RB   = 99;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, kv_a, start_b, kv_b;
    logic [3:0] kc_a, kc_b;
    logic [3:0] rn_a, rn_b, tt_a, tt_b, to_a, to_b;
    logic [7:0] sc_a, sc_b;
    logic       run_a, run_b, go_a, go_b;

    always #5 clk = ~clk;

    typing_game_ctrl #(.TICK_DIV(TA), .ROUND_SECS(RA), .LFSR_SEED(SEED)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .key_valid(kv_a), .key_code(kc_a),
        .random_num(rn_a), .score(sc_a), .time_tens(tt_a), .time_ones(to_a),
        .running(run_a), .game_over(go_a)
    );

    typing_game_ctrl #(.TICK_DIV(TB), .ROUND_SECS(RB), .LFSR_SEED(SEED)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .key_valid(kv_b), .key_code(kc_b),
        .random_num(rn_b), .score(sc_b), .time_tens(tt_b), .time_ones(to_b),
        .running(run_b), .game_over(go_b)
    );

    // Reference LFSR, independent of the DUT, taps 16,14,13,11
    logic [15:0] m;
    always @(posedge clk or posedge reset) begin
        if (reset) m <= SEED;
        else       m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end

    int checks = 0;
    int errors = 0;

    logic [3:0] tgt [2];
    int         sc  [2];

    typedef struct {
        logic [7:0] score;
        logic [3:0] num;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit         correct;
        int         reps;
        logic [7:0] exp_score;
    } vec_t;
    vec_t tbl [6];

    function automatic logic [3:0] draw(input logic [15:0] v);
        logic [3:0] c;
        c = v[3:0];
        return (c > 4'd9) ? c - 4'd6 : c;
    endfunction

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic press(input int d, input bit correct);
        logic [3:0]  code;
        logic [15:0] pre;
        exp_t        e;
        exp_t        got;
        if (correct) code = tgt[d];
        else         code = (tgt[d] == 4'd0) ? 4'hC : tgt[d] - 4'd1;
        if (d == 0) begin kv_a = 1'b1; kc_a = code; end
        else        begin kv_b = 1'b1; kc_b = code; end
        @(negedge clk);
        pre  = m;
        kv_a = 1'b0;
        kv_b = 1'b0;
        if (correct) begin
            sc[d]  = (sc[d] < 99) ? sc[d] + 1 : 99;
            tgt[d] = draw(pre);
        end else begin
`ifdef TYPING_PENALTY_EN
            sc[d]  = (sc[d] > 0) ? sc[d] - 1 : 0;
            tgt[d] = draw(pre);
`endif
        end
        e.score = bcd(sc[d]);
        e.num   = tgt[d];
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        if (d == 0) begin
            check("key_score_a", 16'(sc_a), 16'(got.score));
            check("key_target_a", 16'(rn_a), 16'(got.num));
        end else begin
            check("key_score_b", 16'(sc_b), 16'(got.score));
            check("key_target_b", 16'(rn_b), 16'(got.num));
        end
    endtask

    task automatic start_pulse(input int d);
        logic [15:0] pre;
        if (d == 0) start_a = 1'b1; else start_b = 1'b1;
        pre = m;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        tgt[d]  = draw(pre);
        sc[d]   = 0;
    endtask

    initial begin
        tbl[0] = '{1'b0, 1,  8'h00};
        tbl[1] = '{1'b1, 5,  8'h05};
`ifdef TYPING_PENALTY_EN
        tbl[2] = '{1'b0, 1,  8'h04};
        tbl[3] = '{1'b1, 7,  8'h11};
`else
        tbl[2] = '{1'b0, 1,  8'h05};
        tbl[3] = '{1'b1, 7,  8'h12};
`endif
        tbl[4] = '{1'b1, 88, 8'h99};
        tbl[5] = '{1'b1, 1,  8'h99};

        reset = 1'b1;
        start_a = 1'b0; kv_a = 1'b0; kc_a = 4'd0;
        start_b = 1'b0; kv_b = 1'b0; kc_b = 4'd0;
        tgt[0] = 4'd0; tgt[1] = 4'd0; sc[0] = 0; sc[1] = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_num", 16'(rn_a), 16'(0));
        check("rst_score", 16'(sc_a), 16'(8'h00));
        check("rst_time_a", 16'({tt_a, to_a}), 16'(8'h03));
        check("rst_time_b", 16'({tt_b, to_b}), 16'(8'h99));
        check("rst_running", 16'(run_a), 16'(0));
        check("rst_game_over", 16'(go_a), 16'(0));

        kv_a = 1'b1; kc_a = 4'd0;
        @(negedge clk);
        kv_a = 1'b0;
        @(negedge clk);
        check("idle_key_score", 16'(sc_a), 16'(8'h00));
        check("idle_running", 16'(run_a), 16'(0));

        start_pulse(0);
        check("start_running", 16'(run_a), 16'(1));
        check("start_time", 16'({tt_a, to_a}), 16'(8'h03));
        check("start_target", 16'(rn_a), 16'(tgt[0]));

        for (int k = 2; k >= 0; k--) begin
            repeat (3) @(negedge clk);
            check("time_hold", 16'({tt_a, to_a}), 16'(bcd(k + 1)));
            @(negedge clk);
            check("time_step", 16'({tt_a, to_a}), 16'(bcd(k)));
        end
        check("at_zero_go", 16'(go_a), 16'(0));
        check("at_zero_run", 16'(run_a), 16'(1));
        @(negedge clk);
        check("done_go", 16'(go_a), 16'(1));
        check("done_run", 16'(run_a), 16'(0));
        check("done_time", 16'({tt_a, to_a}), 16'(8'h00));

        kv_a = 1'b1; kc_a = tgt[0];
        @(negedge clk);
        kv_a = 1'b0;
        @(negedge clk);
        check("done_key_score", 16'(sc_a), 16'(8'h00));
        check("done_key_target", 16'(rn_a), 16'(tgt[0]));

        start_pulse(1);
        check("b_running", 16'(run_b), 16'(1));
        check("b_target", 16'(rn_b), 16'(tgt[1]));
        for (int i = 0; i < 6; i++) begin
            for (int r = 0; r < tbl[i].reps; r++)
                press(1, tbl[i].correct);
            check("table_score", 16'(sc_b), 16'(tbl[i].exp_score));
        end

        start_pulse(0);
        check("restart_running", 16'(run_a), 16'(1));
        check("restart_go", 16'(go_a), 16'(0));
        check("restart_time", 16'({tt_a, to_a}), 16'(8'h03));
        check("restart_target", 16'(rn_a), 16'(tgt[0]));
        repeat (3) press(0, 1'b1);
        check("mid_score", 16'(sc_a), 16'(8'h03));
        check("mid_time", 16'({tt_a, to_a}), 16'(8'h02));

        #2 reset = 1'b1;
        #1;
        check("async_num", 16'(rn_a), 16'(0));
        check("async_score", 16'(sc_a), 16'(8'h00));
        check("async_time", 16'({tt_a, to_a}), 16'(8'h03));
        check("async_running", 16'(run_a), 16'(0));
        check("async_go", 16'(go_a), 16'(0));
        check("async_b_score", 16'(sc_b), 16'(8'h00));
        @(negedge clk);
        reset = 1'b0;
        tgt[0] = 4'd0; tgt[1] = 4'd0; sc[0] = 0; sc[1] = 0;
        @(negedge clk);

        start_pulse(0);
        check("post_rst_running", 16'(run_a), 16'(1));
        check("post_rst_score", 16'(sc_a), 16'(8'h00));
        check("post_rst_time", 16'({tt_a, to_a}), 16'(8'h03));
        check("post_rst_target", 16'(rn_a), 16'(tgt[0]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
